// File: rtl/barrel_shift_pkg.sv
// Shared constants and helpers for the barrel_shift ALU shift unit.
package barrel_shift_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned AMT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  // Upper bound on the data width that bit_rev can handle.
  localparam int unsigned MAX_WIDTH = 128;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] v,
                                                   input int unsigned n);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One right-shift mux stage of the barrel shifter; optional circular fill from the LSB end.
module barrel_shift_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHIFT       = 1,
  parameter bit          ROTATE_FILL = 1'b0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             rotate,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] wrapped;

  assign shifted = din >> SHIFT;
  // Bits falling off the LSB end, repositioned at the MSB end.
  assign wrapped = din << (WIDTH - SHIFT);

  always_comb begin
    dout = din;
    if (en) begin
      dout = (ROTATE_FILL && rotate) ? (shifted | wrapped) : shifted;
    end
  end

endmodule

// File: rtl/barrel_shift.sv
// Registered logical barrel shifter (1-cycle latency) with a travelling valid bit.
// Defining BARREL_SHIFT_ROTATE_EN adds a rotate input for circular shifts.
module barrel_shift
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             direction,
`ifdef BARREL_SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  logic             rot_en;
  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] net_out_rev;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] stage_data [AMT_W+1];
  logic [WIDTH-1:0] y_q;
  logic             valid_q;

`ifdef BARREL_SHIFT_ROTATE_EN
  assign rot_en = rotate;
  localparam bit ROTATE_FILL = 1'b1;
`else
  assign rot_en = 1'b0;
  localparam bit ROTATE_FILL = 1'b0;
`endif

  // Left shifts reuse the right-shift network by reversing around it.
  assign a_rev         = WIDTH'(bit_rev(MAX_WIDTH'(a), WIDTH));
  assign stage_data[0] = (direction == DIR_LEFT) ? a_rev : a;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH       (WIDTH),
      .SHIFT       (2 ** k),
      .ROTATE_FILL (ROTATE_FILL)
    ) u_stage (
      .din    (stage_data[k]),
      .en     (amt[k]),
      .rotate (rot_en),
      .dout   (stage_data[k+1])
    );
  end

  assign net_out_rev = WIDTH'(bit_rev(MAX_WIDTH'(stage_data[AMT_W]), WIDTH));
  assign result      = (direction == DIR_LEFT) ? net_out_rev : stage_data[AMT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Load only on valid so idle-cycle X inputs never reach y.
      if (in_valid) y_q <= result;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_barrel_shift.sv
// Self-checking bench for barrel_shift: vector table plus scoreboard, with reset and burst sequences.
module tb_barrel_shift;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        direction;
  logic        rotate;
  logic [31:0] y;
  logic        out_valid;

  always #5 clk = ~clk;

  barrel_shift dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .amt       (amt),
    .direction (direction),
`ifdef BARREL_SHIFT_ROTATE_EN
    .rotate    (rotate),
`endif
    .y         (y),
    .out_valid (out_valid)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  amt;
    logic        dir;
    logic        rot;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    a         = v.a;
    amt       = v.amt;
    direction = v.dir;
    rotate    = v.rot;
    sb.push_back(v.exp);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got y=%h with no pending result", y);
      end else begin
        check("sb_result", y, sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] last;
    int          waitc;

    vecs.push_back('{a: 32'h00000099, amt: 5'd0,  dir: 1'b1, rot: 1'b0, exp: 32'h00000099});
    vecs.push_back('{a: 32'h00000099, amt: 5'd0,  dir: 1'b0, rot: 1'b0, exp: 32'h00000099});
    vecs.push_back('{a: 32'h00000099, amt: 5'd1,  dir: 1'b1, rot: 1'b0, exp: 32'h00000132});
    vecs.push_back('{a: 32'h00000099, amt: 5'd1,  dir: 1'b0, rot: 1'b0, exp: 32'h0000004C});
    vecs.push_back('{a: 32'h00000099, amt: 5'd4,  dir: 1'b1, rot: 1'b0, exp: 32'h00000990});
    vecs.push_back('{a: 32'h00000099, amt: 5'd4,  dir: 1'b0, rot: 1'b0, exp: 32'h00000009});
    vecs.push_back('{a: 32'h00000099, amt: 5'd7,  dir: 1'b1, rot: 1'b0, exp: 32'h00004C80});
    vecs.push_back('{a: 32'h00000099, amt: 5'd7,  dir: 1'b0, rot: 1'b0, exp: 32'h00000001});
    vecs.push_back('{a: 32'h0098C179, amt: 5'd15, dir: 1'b1, rot: 1'b0, exp: 32'h60BC8000});
    vecs.push_back('{a: 32'h0098C179, amt: 5'd15, dir: 1'b0, rot: 1'b0, exp: 32'h00000131});
    vecs.push_back('{a: 32'h80000001, amt: 5'd31, dir: 1'b1, rot: 1'b0, exp: 32'h80000000});
    vecs.push_back('{a: 32'h80000001, amt: 5'd31, dir: 1'b0, rot: 1'b0, exp: 32'h00000001});
    vecs.push_back('{a: 32'hFFFFFFFF, amt: 5'd31, dir: 1'b0, rot: 1'b0, exp: 32'h00000001});
    vecs.push_back('{a: 32'h80000001, amt: 5'd1,  dir: 1'b1, rot: 1'b0, exp: 32'h00000002});
    vecs.push_back('{a: 32'h80000001, amt: 5'd1,  dir: 1'b0, rot: 1'b0, exp: 32'h40000000});
`ifdef BARREL_SHIFT_ROTATE_EN
    vecs.push_back('{a: 32'h80000001, amt: 5'd1,  dir: 1'b1, rot: 1'b1, exp: 32'h00000003});
    vecs.push_back('{a: 32'h80000001, amt: 5'd1,  dir: 1'b0, rot: 1'b1, exp: 32'hC0000000});
`else
    // Without the rotate port the request degrades to a logical shift.
    vecs.push_back('{a: 32'h80000001, amt: 5'd1,  dir: 1'b1, rot: 1'b1, exp: 32'h00000002});
    vecs.push_back('{a: 32'h80000001, amt: 5'd1,  dir: 1'b0, rot: 1'b1, exp: 32'h40000000});
`endif

    // Reset holds outputs low even with in_valid asserted.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 32'hFFFFFFFF;
    amt       = 5'd3;
    direction = 1'b1;
    rotate    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_y", y, 32'h0);
      check("reset_valid", {31'b0, out_valid}, 32'h0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_y", y, 32'h0);
    check("post_reset_valid", {31'b0, out_valid}, 32'h0);
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Back-to-back burst, then idle with X inputs: y must hold the last result.
    vecs.delete();
    vecs.push_back('{a: 32'h12345678, amt: 5'd4,  dir: 1'b1, rot: 1'b0, exp: 32'h23456780});
    vecs.push_back('{a: 32'h12345678, amt: 5'd8,  dir: 1'b0, rot: 1'b0, exp: 32'h00123456});
    vecs.push_back('{a: 32'hF0F0F0F0, amt: 5'd16, dir: 1'b1, rot: 1'b0, exp: 32'hF0F00000});
    vecs.push_back('{a: 32'hDEADBEEF, amt: 5'd1,  dir: 1'b0, rot: 1'b0, exp: 32'h6F56DF77});
    last = 32'h6F56DF77;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check("burst_valid", {31'b0, out_valid}, 32'h1);
    end
    in_valid  = 1'b0;
    a         = 'x;
    amt       = 'x;
    direction = 'x;
    rotate    = 'x;
    repeat (2) begin
      @(negedge clk);
      check("idle_valid", {31'b0, out_valid}, 32'h0);
      check("idle_hold_y", y, last);
    end

    waitc = 0;
    while (sb.size() != 0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
